gen_32_source: RTL and testbench
================================

Name: gen_32_source

Overview:
- Test-pattern source directly upstream of the 32-to-16 stream adapter in the SDRAM stream-test datapath.
- Emits a programmable-length burst of 32-bit words, either an incrementing counter or PRBS32, each qualified by a one-cycle num_32_rdy pulse.
- Pulses are never issued on consecutive cycles, because the downstream adapter needs two cycles per 32-bit word to produce its two 16-bit halves.
- Honours a hold (FIFO almost-full) input and reports busy and done to the test controller.

Parameters:
- GAP, 2: minimum number of clk cycles between successive num_32_rdy pulses. GAP < 2 is an elaboration error.
- LFSR_SEED, 32'h0000_0001: first word in PRBS mode. A value of 0 is replaced by 1.
- POLY, 32'h0040_0007: Galois feedback mask for x^32+x^22+x^2+x+1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a burst; sampled only in IDLE.
- mode  input  1  0 = counter, 1 = PRBS32; latched at start.
- burst_len  input  16  number of words in the burst; latched at start.
- hold  input  1  downstream backpressure; blocks the next emission while high.
- stream_32  output  32  data word; registered, stable between pulses.
- num_32_rdy  output  1  one-cycle strobe marking stream_32 as a new valid word; registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at the end of a burst.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; stream_32 = 0; num_32_rdy, busy, done = 0; word and gap counters = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start = 1, latch mode and burst_len, load the data register with 0 (counter mode) or LFSR_SEED (PRBS mode), and clear gap_cnt and word_cnt.
  - If burst_len = 0, go to DONE; otherwise go to RUN.
- RUN, emission: when gap_cnt = 0 and hold = 0, then on that edge:
  - stream_32 <= data register and num_32_rdy <= 1;
  - data register advances;
  - gap_cnt <= GAP-1;
  - word_cnt increments.
- RUN, otherwise: num_32_rdy <= 0, and gap_cnt decrements when non-zero.
- RUN, end of burst: the edge that emits word number burst_len also moves the FSM to DONE.
- DONE: done = 1 for exactly one cycle (registered), then IDLE. busy is low in DONE and IDLE.
- Latency:
  - start sampled on edge k puts the FSM in RUN after edge k.
  - First num_32_rdy is high in the cycle after edge k+1, given hold = 0.
  - With hold = 0, pulses are exactly GAP cycles apart.
- hold:
  - Only blocks the decision at gap_cnt = 0; gap counting continues while hold is high.
  - When hold falls, emission occurs on the next edge.
  - hold never truncates a pulse that has already been asserted.
- Counter mode: words are 0, 1, 2, … The 32-bit value wraps 0xFFFF_FFFF -> 0 (relevant only for a start value above 0xFFFF_0000, which does not occur with a 16-bit length).
- PRBS mode: next = {w[30:0], 1'b0} ^ (w[31] ? POLY : 0).
- stream_32 holds the last emitted word after the burst until the next emission or reset.
- start while in RUN or DONE is ignored. The latched mode and burst_len are unaffected by input changes mid-burst.
- rst mid-burst aborts immediately; no done pulse is produced.

Decomposition:
- Shared package:
  - state encoding (IDLE, RUN, DONE);
  - mode constants (MODE_CNT = 0, MODE_PRBS = 1);
  - default POLY and seed.
- Natural sub-module: prbs32_next, combinational one-step Galois LFSR. Instantiated once and reusable by the downstream checker.

Test Plan:
- Counter, GAP = 2, burst_len = 4, hold = 0 -> num_32_rdy high every 2nd cycle, 4 pulses, stream_32 = 0, 1, 2, 3. First pulse 2 cycles after start; done pulses one cycle after the 4th rdy; busy high for the 7 RUN cycles.
- PRBS, LFSR_SEED = 32'h8000_0000, burst_len = 3 -> words 0x8000_0000, 0x0040_0007, 0x0080_000E.
- burst_len = 0 -> no num_32_rdy; done high exactly one cycle, 2 cycles after start; busy stays 0.
- Counter, GAP = 3, burst_len = 3, hold high for 5 cycles starting just before the 2nd pulse -> 2nd word (1) appears on the edge after hold falls. Gaps before and after are 3 cycles and the held gap is longer; values stay in sequence 0, 1, 2.
- Second start asserted mid-burst -> ignored: total pulses = burst_len, and counter values are not restarted.
- rst asserted asynchronously between pulses 2 and 3 of a 6-word burst -> all outputs 0 immediately, no done. A new start then restarts the counter at 0.

Source files
------------

// File: rtl/gen_32_source_pkg.sv
// Shared constants for the 32-bit test-pattern source and its downstream checker.
// Covers state encoding, pattern mode codes and default LFSR settings.
package gen_32_source_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_CNT  = 1'b0;
    localparam logic MODE_PRBS = 1'b1;

    // Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] DEFAULT_POLY = 32'h0040_0007;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // An all-zero LFSR state would lock up, so zero is mapped to one.
    function automatic logic [31:0] safe_seed(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/gen_32_source_prbs32_next.sv
// One-step combinational Galois LFSR advance for PRBS32.
// Shared by the pattern source and the downstream data checker.
module prbs32_next
    import gen_32_source_pkg::*;
#(
    parameter logic [31:0] POLY = DEFAULT_POLY
) (
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    assign nxt = {cur[30:0], 1'b0} ^ (cur[31] ? POLY : 32'd0);

endmodule

// File: rtl/gen_32_source.sv
// Burst test-pattern source: counter or PRBS32 words, one strobe at most every GAP cycles,
// so the 32-to-16 adapter downstream always has two cycles per word.
module gen_32_source
    import gen_32_source_pkg::*;
#(
    parameter int          GAP       = 2,
    parameter logic [31:0] LFSR_SEED = DEFAULT_SEED,
    parameter logic [31:0] POLY      = DEFAULT_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] burst_len,
    input  logic        hold,
    output logic [31:0] stream_32,
    output logic        num_32_rdy,
    output logic        busy,
    output logic        done
);

    if (GAP < 2) begin : g_gap_check
        $error("gen_32_source: GAP must be at least 2");
    end

    localparam int          GW       = (GAP < 2) ? 1 : $clog2(GAP);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 1);
    localparam logic [31:0] SEED_EFF = safe_seed(LFSR_SEED);

    logic [1:0]    state;
    logic          mode_q;
    logic [15:0]   len_q;
    logic [15:0]   word_cnt;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   data_reg;
    logic [31:0]   prbs_nxt;
    logic [31:0]   data_nxt;
    logic          emit;

    prbs32_next #(.POLY(POLY)) u_prbs (
        .cur (data_reg),
        .nxt (prbs_nxt)
    );

    assign data_nxt = (mode_q == MODE_PRBS) ? prbs_nxt : data_reg + 32'd1;
    // hold gates only the emission decision; the gap countdown runs regardless.
    assign emit     = (state == ST_RUN) && (gap_cnt == '0) && !hold;

    // NOTE: every state element uses <= so all updates see pre-edge values,
    // regardless of statement order inside the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_CNT;
            len_q      <= '0;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            data_reg   <= '0;
            stream_32  <= '0;
            num_32_rdy <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            num_32_rdy <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        len_q    <= burst_len;
                        data_reg <= (mode == MODE_PRBS) ? SEED_EFF : 32'd0;
                        gap_cnt  <= '0;
                        word_cnt <= '0;
                        if (burst_len == 16'd0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (emit) begin
                        stream_32  <= data_reg;
                        num_32_rdy <= 1'b1;
                        data_reg   <= data_nxt;
                        gap_cnt    <= GAP_RELOAD;
                        word_cnt   <= word_cnt + 16'd1;
                        if (word_cnt == len_q - 16'd1) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                        end
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_32_source.sv
// Directed bench for gen_32_source: table of bursts on three parameterisations,
// plus hand-written reset sequences.
module tb_gen_32_source;
    import gen_32_source_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [15:0] burst_len;
    logic        hold;
    logic        start_a, start_p, start_c;

    logic [31:0] stream_a, stream_p, stream_c;
    logic        rdy_a, rdy_p, rdy_c;
    logic        busy_a, busy_p, busy_c;
    logic        done_a, done_p, done_c;

    always #5 clk = ~clk;

    gen_32_source #(.GAP(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .burst_len(burst_len),
        .hold(hold), .stream_32(stream_a), .num_32_rdy(rdy_a), .busy(busy_a), .done(done_a));

    gen_32_source #(.GAP(2), .LFSR_SEED(32'h8000_0000)) dut_p (
        .clk(clk), .rst(rst), .start(start_p), .mode(mode), .burst_len(burst_len),
        .hold(hold), .stream_32(stream_p), .num_32_rdy(rdy_p), .busy(busy_p), .done(done_p));

    gen_32_source #(.GAP(3)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode), .burst_len(burst_len),
        .hold(hold), .stream_32(stream_c), .num_32_rdy(rdy_c), .busy(busy_c), .done(done_c));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  cur_inst = 2'd0;
    logic [31:0] sel_stream;
    logic        sel_rdy, sel_busy, sel_done;

    always_comb begin
        sel_stream = stream_a;
        sel_rdy    = rdy_a;
        sel_busy   = busy_a;
        sel_done   = done_a;
        case (cur_inst)
            2'd1: begin
                sel_stream = stream_p; sel_rdy = rdy_p; sel_busy = busy_p; sel_done = done_p;
            end
            2'd2: begin
                sel_stream = stream_c; sel_rdy = rdy_c; sel_busy = busy_c; sel_done = done_c;
            end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [1:0]       inst;
        logic             m;
        logic [15:0]      len;
        logic [7:0]       hold_from;
        logic [7:0]       hold_len;
        logic [7:0]       restart_at;
        logic [7:0]       exp_n;
        logic [3:0][31:0] exp_w;
        logic [3:0][7:0]  exp_c;
        logic [7:0]       exp_done;
        logic [7:0]       exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic [1:0] inst, input logic v);
        case (inst)
            2'd1:    start_p = v;
            2'd2:    start_c = v;
            default: start_a = v;
        endcase
    endtask

    function automatic vec_t mk(input int inst, input logic m, input int len,
                                input int hf, input int hl, input int rs, input int n,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input int c0, input int c1, input int c2, input int c3,
                                input int dc, input int bc);
        vec_t v;
        v.inst = 2'(inst); v.m = m; v.len = 16'(len);
        v.hold_from = 8'(hf); v.hold_len = 8'(hl); v.restart_at = 8'(rs);
        v.exp_n = 8'(n);
        v.exp_w[0] = w0; v.exp_w[1] = w1; v.exp_w[2] = w2; v.exp_w[3] = w3;
        v.exp_c[0] = 8'(c0); v.exp_c[1] = 8'(c1); v.exp_c[2] = 8'(c2); v.exp_c[3] = 8'(c3);
        v.exp_done = 8'(dc); v.exp_busy = 8'(bc);
        return v;
    endfunction

    // Starts a burst on one instance and observes 20 cycles; cycle 1 is the
    // cycle after the edge that samples start. Inputs are scrambled afterwards
    // to show mode and burst_len were latched.
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] got_w [8];
        int          got_c [8];
        int          n    = 0;
        int          dcnt = 0;
        int          dcyc = 0;
        int          bcnt = 0;
        for (int i = 0; i < 8; i++) begin got_w[i] = '0; got_c[i] = 0; end
        cur_inst = v.inst;
        @(negedge clk);
        mode      = v.m;
        burst_len = v.len;
        set_start(v.inst, 1'b1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (sel_rdy) begin
                if (n < 8) begin got_w[n] = sel_stream; got_c[n] = cyc; end
                n++;
            end
            if (sel_done) begin dcnt++; dcyc = cyc; end
            if (sel_busy) bcnt++;
            if (cyc == 1) begin
                set_start(v.inst, 1'b0);
                mode      = ~v.m;
                burst_len = 16'd9;
            end
            if (v.restart_at != 0 && cyc == int'(v.restart_at))     set_start(v.inst, 1'b1);
            if (v.restart_at != 0 && cyc == int'(v.restart_at) + 1) set_start(v.inst, 1'b0);
            if (v.hold_len != 0 && cyc == int'(v.hold_from))                    hold = 1'b1;
            if (v.hold_len != 0 && cyc == int'(v.hold_from) + int'(v.hold_len)) hold = 1'b0;
        end
        check($sformatf("v%0d pulses", idx), 32'(n), 32'(v.exp_n));
        for (int i = 0; i < int'(v.exp_n) && i < 4; i++) begin
            check($sformatf("v%0d word%0d", idx, i), got_w[i], v.exp_w[i]);
            check($sformatf("v%0d cyc%0d", idx, i), 32'(got_c[i]), 32'(v.exp_c[i]));
        end
        check($sformatf("v%0d done_count", idx), 32'(dcnt), 32'd1);
        check($sformatf("v%0d done_cycle", idx), 32'(dcyc), 32'(v.exp_done));
        check($sformatf("v%0d busy_cycles", idx), 32'(bcnt), 32'(v.exp_busy));
        if (v.exp_n != 0)
            check($sformatf("v%0d stream_holds", idx), sel_stream, v.exp_w[int'(v.exp_n) - 1]);
    endtask

    vec_t vecs [8];

    initial begin
        int n_after;
        int d_after;

        //             inst mode       len hf hl rs n  words                                        cycles         done busy
        vecs[0] = mk(0, MODE_CNT,  4, 0, 0, 0, 4, 32'd0, 32'd1, 32'd2, 32'd3,                 2, 4, 6, 8,   9,  7);
        vecs[1] = mk(1, MODE_PRBS, 3, 0, 0, 0, 3, 32'h8000_0000, 32'h0040_0007, 32'h0080_000E, 32'd0, 2, 4, 6, 0, 7, 5);
        vecs[2] = mk(0, MODE_PRBS, 3, 0, 0, 0, 3, 32'd1, 32'd2, 32'd4, 32'd0,                 2, 4, 6, 0,   7,  5);
        vecs[3] = mk(0, MODE_CNT,  0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0,                 0, 0, 0, 0,   2,  0);
        vecs[4] = mk(0, MODE_CNT,  1, 0, 0, 0, 1, 32'd0, 32'd0, 32'd0, 32'd0,                 2, 0, 0, 0,   3,  1);
        vecs[5] = mk(2, MODE_CNT,  3, 0, 0, 0, 3, 32'd0, 32'd1, 32'd2, 32'd0,                 2, 5, 8, 0,   9,  7);
        vecs[6] = mk(2, MODE_CNT,  3, 4, 5, 0, 3, 32'd0, 32'd1, 32'd2, 32'd0,                 2, 10, 13, 0, 14, 12);
        vecs[7] = mk(0, MODE_CNT,  4, 0, 0, 3, 4, 32'd0, 32'd1, 32'd2, 32'd3,                 2, 4, 6, 8,   9,  7);

        rst = 1'b1; mode = 1'b0; burst_len = '0; hold = 1'b0;
        start_a = 1'b0; start_p = 1'b0; start_c = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", {stream_a, 28'd0, rdy_a, busy_a, done_a, 1'b0} == '0 ? 32'd0 : 32'd1, 32'd0);
        check("reset_p", {31'd0, rdy_p | busy_p | done_p | (|stream_p)}, 32'd0);
        check("reset_c", {31'd0, rdy_c | busy_c | done_c | (|stream_c)}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Asynchronous reset between pulses 2 and 3 of a 6-word counter burst.
        cur_inst = 2'd0;
        @(negedge clk);
        mode = MODE_CNT; burst_len = 16'd6; start_a = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start_a = 1'b0;
        end
        check("pre_rst_stream", stream_a, 32'd1);
        check("pre_rst_busy", {31'd0, busy_a}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_stream", stream_a, 32'd0);
        check("async_rst_flags", {29'd0, rdy_a, busy_a, done_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_after = 0; d_after = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (rdy_a)  n_after++;
            if (done_a) d_after++;
        end
        check("post_rst_pulses", 32'(n_after), 32'd0);
        check("post_rst_done", 32'(d_after), 32'd0);

        run_vec(8, mk(0, MODE_CNT, 2, 0, 0, 0, 2, 32'd0, 32'd1, 32'd0, 32'd0, 2, 4, 0, 0, 5, 3));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
